// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the RV32I pipeline control blocks.
// The source-register match rule is kept here so every hazard term uses the same definition.
package rv_pipe_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } mstate_t;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    // x0 never carries a dependence, and only operands the ID instruction actually reads count.
    function automatic logic reg_match(
        input logic [4:0] r,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use1,
        input logic       use2
    );
        return (r != REG_ZERO) && ((use1 && (r == rs1)) || (use2 && (r == rs2)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational detection of the two load-related hazards that forwarding cannot hide.
module hazard_detect
    import rv_pipe_pkg::*;
(
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_use_rs1,
    input  logic       i_id_use_rs2,
    input  logic       i_id_is_branch,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_mem_read,
    output logic       o_load_use,
    output logic       o_br_load
);

    logic w_ex_match;
    logic w_mem_match;

    assign w_ex_match  = reg_match(i_ex_rd,  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2);
    assign w_mem_match = reg_match(i_mem_rd, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2);

    // A branch compares in ID, and the MEM forwarding path only has the ALU result, not load data.
    assign o_load_use = i_ex_mem_read && w_ex_match;
    assign o_br_load  = i_id_is_branch && i_mem_mem_read && w_mem_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I core: load hazards, data-memory waits,
// ID branch redirects (with wrong-path fetch discard) and a saturating frontend-stall counter.
module pipeline_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_is_branch,
    input  logic             branch_taken,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_mem_read,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             imem_valid,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             w_load_use;
    logic             w_br_load;
    logic             w_hazard;
    logic             w_mem_stall;
    mstate_t          r_mstate;
    logic             r_drop_pend;
    logic [CNT_W-1:0] r_stall_cnt;

    hazard_detect u_hazard_detect (
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_use_rs1   (id_use_rs1),
        .i_id_use_rs2   (id_use_rs2),
        .i_id_is_branch (id_is_branch),
        .i_ex_rd        (ex_rd),
        .i_ex_mem_read  (ex_mem_read),
        .i_mem_rd       (mem_rd),
        .i_mem_mem_read (mem_mem_read),
        .o_load_use     (w_load_use),
        .o_br_load      (w_br_load)
    );

    assign w_hazard    = w_load_use || w_br_load;
    assign w_mem_stall = dmem_req && !dmem_ready;
    assign stall_cnt   = r_stall_cnt;

    // Priority mux: reset, memory freeze, hazard bubble, redirect, wrong-path drop, fetch bubble.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            ex_mem_en   = 1'b0;
            mem_wb_en   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_mem_stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (w_hazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
        end else if (r_drop_pend) begin
            pc_en       = imem_valid;
            if_id_flush = 1'b1;
        end else if (!imem_valid) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    // A redirect without fetch data leaves the old fetch in flight; its arrival must be discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstate    <= RUN;
            r_drop_pend <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (r_mstate == RUN) begin
                if (w_mem_stall) r_mstate <= MWAIT;
            end else if (dmem_ready) begin
                r_mstate <= RUN;
            end
            if (!w_mem_stall && !w_hazard) begin
                if (branch_taken) r_drop_pend <= !imem_valid;
                else if (r_drop_pend && imem_valid) r_drop_pend <= 1'b0;
            end
            if (!pc_en && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic,
// each checked against a cycle-level model of the stall/flush rules (4-bit counter to reach saturation).
module tb_pipeline_hazard_ctrl;
    import rv_pipe_pkg::*;

    localparam int CW   = 4;
    localparam int MAXC = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd, mem_rd;
    logic          id_use_rs1, id_use_rs2, id_is_branch, branch_taken;
    logic          ex_mem_read, mem_mem_read, dmem_req, dmem_ready, imem_valid;
    logic          pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en;
    logic [CW-1:0] stall_cnt;
    logic [5:0]    obs;

    int  checks = 0;
    int  errors = 0;
    bit  m_wait;
    bit  m_drop;
    int  m_cnt;

    pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_branch(id_is_branch), .branch_taken(branch_taken),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .imem_valid(imem_valid),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Bit order everywhere: {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en}
    assign obs = {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en};

    function automatic bit depends_on(input logic [4:0] r);
        return (r != 5'd0) && ((id_use_rs1 && r == id_rs1) || (id_use_rs2 && r == id_rs2));
    endfunction

    function automatic bit model_hazard();
        return (ex_mem_read && depends_on(ex_rd)) ||
               (id_is_branch && mem_mem_read && depends_on(mem_rd));
    endfunction

    function automatic logic [5:0] model_ctrl();
        if (rst)                          return 6'b001100;
        if (dmem_req && !dmem_ready)      return 6'b000000;
        if (model_hazard())               return 6'b000111;
        if (branch_taken)                 return 6'b111011;
        if (m_drop)                       return {imem_valid, 5'b11011};
        if (!imem_valid)                  return 6'b011011;
        return 6'b110011;
    endfunction

    // Commit the model's view of one clock edge using the inputs currently applied.
    task automatic adv();
        logic [5:0] e;
        bit         frozen, nw, nd;
        int         nc;
        e      = model_ctrl();
        frozen = dmem_req && !dmem_ready;
        nw = m_wait; nd = m_drop; nc = m_cnt;
        if (rst) begin
            nw = 0; nd = 0; nc = 0;
        end else begin
            nw = m_wait ? !dmem_ready : frozen;
            if (!frozen && !model_hazard()) begin
                if (branch_taken)             nd = !imem_valid;
                else if (m_drop && imem_valid) nd = 0;
            end
            if (!e[5] && m_cnt < MAXC) nc = m_cnt + 1;
        end
        @(posedge clk);
        m_wait = nw; m_drop = nd; m_cnt = nc;
    endtask

    task automatic set_idle();
        rst = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_is_branch = 0; branch_taken = 0; ex_rd = 0; ex_mem_read = 0;
        mem_rd = 0; mem_mem_read = 0; dmem_req = 0; dmem_ready = 0; imem_valid = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_idle(); rst = 1;
        #1;
        checks++;
        if (obs !== 6'b001100) begin errors++; $display("FAIL reset_ctrl: got %b required %b", obs, 6'b001100); end
        adv();
        @(negedge clk); set_idle(); rst = 1; adv();
        @(negedge clk); set_idle(); #1;
        checks++;
        if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d required 0", stall_cnt); end
        checks++;
        if (dut.r_mstate !== RUN || dut.r_drop_pend !== 1'b0) begin
            errors++; $display("FAIL reset_state: got mstate=%0d drop=%b required 0/0", dut.r_mstate, dut.r_drop_pend);
        end
        checks++;
        if (obs !== 6'b110011) begin errors++; $display("FAIL reset_run: got %b required %b", obs, 6'b110011); end
        adv();
    endtask

    task automatic test_load_use();
        @(negedge clk);
        set_idle(); ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 7; id_use_rs2 = 1;
        #1;
        checks++;
        if (obs !== 6'b000111) begin errors++; $display("FAIL load_use_stall: got %b required %b", obs, 6'b000111); end
        adv();
        @(negedge clk);
        set_idle(); mem_mem_read = 1; mem_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        #1;
        checks++;
        if (obs !== 6'b110011) begin errors++; $display("FAIL load_use_release: got %b required %b", obs, 6'b110011); end
        checks++;
        if (stall_cnt !== 4'd1) begin errors++; $display("FAIL load_use_cnt: got %0d required 1", stall_cnt); end
        adv();
        // x0 never creates a dependence
        @(negedge clk);
        set_idle(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        #1;
        checks++;
        if (obs !== 6'b110011) begin errors++; $display("FAIL load_use_x0: got %b required %b", obs, 6'b110011); end
        adv();
    endtask

    task automatic test_branch_load();
        @(negedge clk);
        set_idle(); ex_mem_read = 1; ex_rd = 6; id_rs2 = 6; id_use_rs2 = 1; id_use_rs1 = 1; id_rs1 = 3;
        id_is_branch = 1; branch_taken = 1;
        #1;
        checks++;
        if (obs !== 6'b000111) begin errors++; $display("FAIL br_load_stall1: got %b required %b", obs, 6'b000111); end
        adv();
        @(negedge clk);
        ex_mem_read = 0; ex_rd = 0; mem_mem_read = 1; mem_rd = 6;
        #1;
        checks++;
        if (obs !== 6'b000111) begin errors++; $display("FAIL br_load_stall2: got %b required %b", obs, 6'b000111); end
        adv();
        @(negedge clk);
        mem_mem_read = 0; mem_rd = 0;
        #1;
        checks++;
        if (obs !== 6'b111011) begin errors++; $display("FAIL br_load_redirect: got %b required %b", obs, 6'b111011); end
        checks++;
        if (stall_cnt !== CW'(m_cnt)) begin errors++; $display("FAIL br_load_cnt: got %0d required %0d", stall_cnt, m_cnt); end
        adv();
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_idle(); dmem_req = 1; dmem_ready = 0; branch_taken = (i == 1);
            #1;
            checks++;
            if (obs !== 6'b000000) begin errors++; $display("FAIL mem_wait_freeze%0d: got %b required %b", i, obs, 6'b000000); end
            if (i > 0) begin
                checks++;
                if (dut.r_mstate !== MWAIT) begin errors++; $display("FAIL mem_wait_state%0d: got %0d required MWAIT", i, dut.r_mstate); end
            end
            adv();
        end
        @(negedge clk);
        set_idle(); dmem_req = 1; dmem_ready = 1;
        #1;
        checks++;
        if (obs !== 6'b110011) begin errors++; $display("FAIL mem_wait_release: got %b required %b", obs, 6'b110011); end
        adv();
        @(negedge clk);
        #1;
        checks++;
        if (dut.r_mstate !== RUN || obs !== 6'b110011) begin
            errors++; $display("FAIL mem_same_cycle: got mstate=%0d ctrl=%b required RUN %b", dut.r_mstate, obs, 6'b110011);
        end
        adv();
    endtask

    task automatic test_drop_pend();
        logic [5:0] want [4] = '{6'b111011, 6'b011011, 6'b111011, 6'b110011};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_idle(); branch_taken = (i == 0); imem_valid = (i >= 2);
            #1;
            checks++;
            if (obs !== want[i]) begin errors++; $display("FAIL drop_pend_step%0d: got %b required %b", i, obs, want[i]); end
            if (i == 1 || i == 2) begin
                checks++;
                if (dut.r_drop_pend !== 1'b1) begin errors++; $display("FAIL drop_pend_set%0d: got %b required 1", i, dut.r_drop_pend); end
            end
            adv();
        end
    endtask

    task automatic test_freeze_priority();
        @(negedge clk);
        set_idle(); dmem_req = 1; dmem_ready = 0; ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1;
        branch_taken = 1; imem_valid = 0;
        #1;
        checks++;
        if (obs !== 6'b000000) begin errors++; $display("FAIL freeze_prio: got %b required %b", obs, 6'b000000); end
        adv();
        @(negedge clk);
        dmem_ready = 1;
        #1;
        checks++;
        if (obs !== 6'b000111) begin errors++; $display("FAIL freeze_then_hazard: got %b required %b", obs, 6'b000111); end
        checks++;
        if (dut.r_drop_pend !== 1'b0) begin errors++; $display("FAIL freeze_drop_held: got %b required 0", dut.r_drop_pend); end
        adv();
    endtask

    task automatic test_reset_mid();
        @(negedge clk); set_idle(); branch_taken = 1; imem_valid = 0; adv();
        @(negedge clk); set_idle(); imem_valid = 0; dmem_req = 1; adv();
        @(negedge clk); set_idle(); dmem_req = 1; rst = 1; adv();
        @(negedge clk); set_idle();
        #1;
        checks++;
        if (dut.r_mstate !== RUN || dut.r_drop_pend !== 1'b0 || stall_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_mid: got mstate=%0d drop=%b cnt=%0d required RUN/0/0", dut.r_mstate, dut.r_drop_pend, stall_cnt);
        end
        adv();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); set_idle(); imem_valid = 0; adv();
        end
        @(negedge clk); set_idle();
        #1;
        checks++;
        if (stall_cnt !== 4'hF) begin errors++; $display("FAIL cnt_saturate: got %0h required f", stall_cnt); end
        adv();
    endtask

    task automatic test_random();
        logic [5:0] e;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst          = ($urandom_range(0, 59) == 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_use_rs1   = 1'($urandom);
            id_use_rs2   = 1'($urandom);
            id_is_branch = 1'($urandom);
            branch_taken = id_is_branch && ($urandom_range(0, 1) == 1);
            ex_rd        = 5'($urandom_range(0, 3));
            ex_mem_read  = ($urandom_range(0, 2) == 0);
            mem_rd       = 5'($urandom_range(0, 3));
            mem_mem_read = ($urandom_range(0, 2) == 0);
            dmem_req     = ($urandom_range(0, 3) == 0);
            dmem_ready   = 1'($urandom);
            imem_valid   = ($urandom_range(0, 3) != 0);
            #1;
            e = model_ctrl();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL random_ctrl@%0d: got %b required %b", i, obs, e); end
            checks++;
            if (stall_cnt !== CW'(m_cnt)) begin errors++; $display("FAIL random_cnt@%0d: got %0d required %0d", i, stall_cnt, m_cnt); end
            adv();
        end
    endtask

    initial begin
        m_wait = 0; m_drop = 0; m_cnt = 0;
        set_idle();
        test_reset();
        test_load_use();
        test_branch_load();
        test_mem_wait();
        test_drop_pend();
        test_freeze_priority();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
